// File: rtl/calculator_pkg.sv
// ---------------------------------------------------------------------------
// calculator_pkg : shared types and constants for the calculator core
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package calculator_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // All-ones fill; the top slices off 2*WIDTH bits
  localparam logic [63:0] DIV0_RESULT = '1;

endpackage

`default_nettype wire

// File: rtl/calculator_muldiv_unit.sv
// ---------------------------------------------------------------------------
// calculator_muldiv_unit : iterative shift-add multiplier / restoring divider
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module calculator_muldiv_unit
  import calculator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  op_t                  i_op,
  input  logic                 i_step,
  input  logic [CW-1:0]        i_cnt,
  output logic                 o_done,
  output logic [2*WIDTH-1:0]   o_result
);

  // mul: r_acc = partial product, r_mcand = shifted multiplicand, r_sh = multiplier
  // div: r_acc[W-1:0] = remainder, r_mcand[W-1:0] = divisor, r_sh = dividend -> quotient
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_sh;

  logic [2*WIDTH-1:0] w_acc_n;
  logic [WIDTH-1:0]   w_sh_n;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;

  always_comb begin
    w_acc_n = r_acc;
    w_sh_n  = r_sh;
    w_shift = '0;
    w_diff  = '0;
    if (i_op == OP_MUL) begin
      if (r_sh[0]) w_acc_n = r_acc + r_mcand;
      w_sh_n = r_sh >> 1;
    end else begin
      w_shift = {r_acc[WIDTH-1:0], r_sh[WIDTH-1]};
      w_diff  = w_shift - {1'b0, r_mcand[WIDTH-1:0]};
      w_acc_n = {{WIDTH{1'b0}}, (w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0])};
      w_sh_n  = {r_sh[WIDTH-2:0], ~w_diff[WIDTH]};
    end
  end

  // Result reflects the step being taken now so the top can latch it on the final edge
  assign o_result = (i_op == OP_MUL) ? w_acc_n : {w_acc_n[WIDTH-1:0], w_sh_n};
  assign o_done   = i_step && (i_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_sh    <= '0;
    end else if (i_start) begin
      r_acc   <= '0;
      r_mcand <= (i_op == OP_MUL) ? {{WIDTH{1'b0}}, i_a} : {{WIDTH{1'b0}}, i_b};
      r_sh    <= (i_op == OP_MUL) ? i_b : i_a;
    end else if (i_step) begin
      r_acc <= w_acc_n;
      r_sh  <= w_sh_n;
      if (i_op == OP_MUL) r_mcand <= r_mcand << 1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/calculator_core.sv
// ---------------------------------------------------------------------------
// calculator_core : valid/ready calculator (add/sub single-cycle, mul/div iterative)
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module calculator_core
  import calculator_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     operand_A,
  input  logic [WIDTH-1:0]     operand_B,
  input  logic [1:0]           op_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_by_zero,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_armed;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  op_t                  r_op;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_fast;
  logic                 w_step;
  logic                 w_md_done;
  op_t                  w_md_op;
  logic [2*WIDTH-1:0]   w_md_res;
  logic [2*WIDTH-1:0]   w_addsub;

  // in_ready stays low until the first edge after reset release
  assign in_ready    = r_armed && (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign busy        = (r_state != IDLE);
  assign result      = r_result;
  assign div_by_zero = r_dbz;

  assign w_accept = in_valid && in_ready;
  assign w_fast   = (r_op == OP_ADD) || (r_op == OP_SUB) ||
                    ((r_op == OP_DIV) && (r_b == '0));
  assign w_step   = (r_state == CALC) && !w_fast;
  assign w_md_op  = w_accept ? op_t'(op_code) : r_op;
  assign w_addsub = (r_op == OP_SUB) ? ({{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b})
                                     : ({{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b});

  calculator_muldiv_unit #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_muldiv (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept),
    .i_a      (operand_A),
    .i_b      (operand_B),
    .i_op     (w_md_op),
    .i_step   (w_step),
    .i_cnt    (r_cnt),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = CALC;
      CALC:    if (w_fast || w_md_done) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= OP_ADD;
      r_cnt    <= '0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) begin
        r_a   <= operand_A;
        r_b   <= operand_B;
        r_op  <= op_t'(op_code);
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        if ((r_op == OP_ADD) || (r_op == OP_SUB)) begin
          r_result <= w_addsub;
          r_dbz    <= 1'b0;
        end else if (w_fast) begin
          r_result <= DIV0_RESULT[2*WIDTH-1:0];
          r_dbz    <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
          if (w_md_done) begin
            r_result <= w_md_res;
            r_dbz    <= 1'b0;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
